testing_4: RTL and testbench



---
 rtl/testing_4.sv | 108 ++++++++++
 tb/tb_testing_4.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/testing_4.sv
// testing_4 - 32-bit pipelined adder built from four 8-bit ripple slices.
//
// Each stage adds one 8-bit slice of the operands and registers the result.
// The upper operand bits that have not been added yet move forward with
// the stage. The low partial sums that are already done also move forward,
// so that every result stays aligned in its own pipeline slot.
// A new operand pair is accepted every cycle. Operands sampled at edge k
// appear on sum/carry after edge k+3.
//
// Ports:
//   clock    in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset, clears every stage
//   a, b     in   32  unsigned operands
//   cin      in   1   carry-in at bit 0
//   sum      out  32  registered (a + b + cin) mod 2^32
//   carry    out  1   registered carry-out of bit 31
//   ovf      out  1   registered signed overflow (only with TESTING_4_OVF_EN)
//
// Build option: define TESTING_4_OVF_EN to add the ovf output.
module testing_4 (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        carry
`ifdef TESTING_4_OVF_EN
   ,
   output logic        ovf
`endif
);

   localparam int WIDTH = 32;
   localparam int SLICE = 8;

   // stage 1: slice [7:0] done, operand bits [31:8] still pending
   logic [SLICE-1:0]       s1_sum;
   logic                   s1_c;
   logic [WIDTH-1:SLICE]   s1_a, s1_b;
   // stage 2: slices [15:0] done
   logic [2*SLICE-1:0]     s2_sum;
   logic                   s2_c;
   logic [WIDTH-1:2*SLICE] s2_a, s2_b;
   // stage 3: slices [23:0] done
   logic [3*SLICE-1:0]     s3_sum;
   logic                   s3_c;
   logic [WIDTH-1:3*SLICE] s3_a, s3_b;

   logic [SLICE:0] add1, add2, add3, add4;

   always_comb begin
      add1 = {1'b0, a[7:0]}      + {1'b0, b[7:0]}      + {8'd0, cin};
      add2 = {1'b0, s1_a[15:8]}  + {1'b0, s1_b[15:8]}  + {8'd0, s1_c};
      add3 = {1'b0, s2_a[23:16]} + {1'b0, s2_b[23:16]} + {8'd0, s2_c};
      add4 = {1'b0, s3_a[31:24]} + {1'b0, s3_b[31:24]} + {8'd0, s3_c};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_sum <= '0;
         s1_c   <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s2_sum <= '0;
         s2_c   <= 1'b0;
         s2_a   <= '0;
         s2_b   <= '0;
         s3_sum <= '0;
         s3_c   <= 1'b0;
         s3_a   <= '0;
         s3_b   <= '0;
         sum    <= '0;
         carry  <= 1'b0;
      end else begin
         s1_sum <= add1[7:0];
         s1_c   <= add1[8];
         s1_a   <= a[31:8];
         s1_b   <= b[31:8];

         s2_sum <= {add2[7:0], s1_sum};
         s2_c   <= add2[8];
         s2_a   <= s1_a[31:16];
         s2_b   <= s1_b[31:16];

         s3_sum <= {add3[7:0], s2_sum};
         s3_c   <= add3[8];
         s3_a   <= s2_a[31:24];
         s3_b   <= s2_b[31:24];

         sum    <= {add4[7:0], s3_sum};
         carry  <= add4[8];
      end
   end

`ifdef TESTING_4_OVF_EN
   // The operand sign bits reach the last stage together with the top
   // slice, so the overflow flag is registered alongside sum/carry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ovf <= 1'b0;
      end else begin
         ovf <= (s3_a[31] == s3_b[31]) && (add4[7] != s3_a[31]);
      end
   end
`endif

endmodule

// File: tb/tb_testing_4.sv
module tb_testing_4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] a, b;
   logic        cin;
   logic [31:0] sum;
   logic        carry;
`ifdef TESTING_4_OVF_EN
   logic        ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: expected {ovf, carry, sum} for the last four sampled pairs.
   // Index 0 holds the newest pair. The value visible after an edge is the
   // result of the pair sampled three edges earlier.
   logic [33:0] hist [0:3];

   testing_4 dut (
      .clock   (clock),
      .reset_n (reset_n),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .sum     (sum),
      .carry   (carry)
`ifdef TESTING_4_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                           input logic c);
      logic [32:0] full;
      logic        v;
      full = {1'b0, x} + {1'b0, y} + {32'd0, c};
      v    = (x[31] == y[31]) && (full[31] != x[31]);
      return {v, full};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_ref();
      for (int i = 0; i < 4; i++) hist[i] = '0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".sum"},   sum,           hist[3][31:0]);
      check({tag, ".carry"}, 32'(carry),    32'(hist[3][32]));
`ifdef TESTING_4_OVF_EN
      check({tag, ".ovf"},   32'(ovf),      32'(hist[3][33]));
`endif
   endtask

   // Apply one operand pair, let one rising edge sample it, then check.
   task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tc);
      a   = ta;
      b   = tb;
      cin = tc;
      @(posedge clock);
      if (!reset_n) begin
         clear_ref();
      end else begin
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = ref_add(ta, tb, tc);
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic flush(input string tag);
      for (int i = 0; i < 3; i++) step(tag, 32'd0, 32'd0, 1'b0);
   endtask

   initial begin
      clear_ref();
      reset_n = 1'b0;
      a = 32'hFFFF_FFFF;
      b = 32'd1;
      cin = 1'b0;
      #1;
      check_outputs("rst_initial");

      // Reset held for five edges with live operands applied.
      for (int i = 0; i < 5; i++) step("rst_hold", 32'hFFFF_FFFF, 32'd1, 1'b0);

      // Release mid-cycle. The next edge samples normally.
      #3 reset_n = 1'b1;

      step("stream0", 32'd500,   32'd600,   1'b0);
      step("stream1", 32'd500,   32'd600,   1'b0);
      step("stream2", 32'd1500,  32'd11600, 1'b1);
      step("stream3", 32'd50000, 32'd60020, 1'b0);
      check("first_result_1100", sum, 32'd1100);
      step("ripple0", 32'hFFFF_FFFF, 32'd0,         1'b1);
      check("repeat_1100", sum, 32'd1100);
      step("ripple1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check("stream2_13101", sum, 32'd13101);
      step("slice0",  32'h0000_00FF, 32'd1, 1'b0);
      check("stream3_110020", sum, 32'd110020);
      step("slice1",  32'h00FF_FFFF, 32'd1, 1'b0);
      check("ripple0_sum", sum, 32'd0);
      check("ripple0_carry", 32'(carry), 32'd1);
      step("ovf0", 32'h7FFF_FFFF, 32'd1,         1'b0);
      step("ovf1", 32'h8000_0000, 32'h8000_0000, 1'b0);
      check("slice0_sum", sum, 32'h0000_0100);
      step("tail", 32'd0, 32'd0, 1'b0);
      check("slice1_sum", sum, 32'h0100_0000);
      flush("drain");

      // Randomised streaming with bias towards carry-heavy operands.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ~ra;
            1: ra = ra | 32'h00FF_FF00;
            default: ;
         endcase
         step("rand", ra, rb, 1'($urandom));
      end

      // Asynchronous reset asserted between edges clears outputs at once.
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("async_rst_sum",   sum,        32'd0);
      check("async_rst_carry", 32'(carry), 32'd0);
      clear_ref();
      @(negedge clock);
      reset_n = 1'b1;

      // Two pairs in flight, then a 1 ns reset pulse discards them.
      step("pre_pulse0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      step("pre_pulse1", 32'h1234_5678, 32'h1111_1111, 1'b0);
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      clear_ref();
      check("pulse_sum", sum, 32'd0);
      step("after_pulse0", 32'd7, 32'd8, 1'b0);
      step("after_pulse1", 32'd0, 32'd0, 1'b0);
      step("after_pulse2", 32'd0, 32'd0, 1'b0);
      check("lost_result_sum", sum, 32'd0);
      step("after_pulse3", 32'd0, 32'd0, 1'b0);
      check("mid_rst_7p8", sum, 32'd15);
      flush("end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
